// File: rtl/hazard_detection_unit_pkg.sv
// Shared types for the hazard detection unit: scoreboard entry, wait FSM states,
// and the source/destination match helper.
package hazard_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_op;
  } sb_entry_t;

  typedef enum logic {
    RUN,
    WAIT
  } wait_state_t;

  // A live entry that writes a non-zero register read by the ID instruction.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] src1,
                                    input logic [4:0] src2, input logic two_src);
    return e.valid & e.wb_en & (e.dest != REG_ZERO) &
           ((e.dest == src1) | (two_src & (e.dest == src2)));
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// ID-stage / memory-status bundle of the hazard detection unit.
// HAZARD_PERF_CNT_EN adds the stall_cnt / freeze_cnt performance counters.
interface hazard_detection_unit_if;
  logic       forward_en;
  logic [4:0] src1;
  logic [4:0] src2;
  logic       two_src;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       id_mem_w_en;
  logic       flush;
  logic       mem_ready;
  logic       hazard_detected;
  logic       freeze_all;
  logic       mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] freeze_cnt;
`endif

  modport master (
    output forward_en, src1, src2, two_src, id_dest, id_wb_en, id_mem_r_en,
           id_mem_w_en, flush, mem_ready,
    input  hazard_detected, freeze_all, mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt, freeze_cnt
`endif
  );

  modport slave (
    input  forward_en, src1, src2, two_src, id_dest, id_wb_en, id_mem_r_en,
           id_mem_w_en, flush, mem_ready,
    output hazard_detected, freeze_all, mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt, freeze_cnt
`endif
  );
endinterface

// File: rtl/hazard_detection_unit_sb_entry.sv
// One scoreboard stage register: hold has priority over bubble, bubble over load.
module hazard_sb_entry
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      bubble,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      if (bubble) q <= '0;
      else        q <= d;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / no-forward stall detection, memory-wait freeze and sticky timeout.
// Optional HAZARD_PERF_CNT_EN adds stall and freeze cycle counters.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter logic [7:0] MEM_TIMEOUT = 8'd16,
  parameter bit         WB_CHECK    = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  hazard_detection_unit_if.slave hif
);

  sb_entry_t   id_entry, exe_q, mem_q, wb_q;
  logic        freeze, raw, hazard;
  logic        m_exe, m_mem, m_wb;
  wait_state_t state;
  logic [7:0]  wait_cnt, cnt_next;
  logic        timeout_err;
  logic        unused_fields;

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = 1'b1;
    id_entry.dest     = hif.id_dest;
    id_entry.wb_en    = hif.id_wb_en;
    id_entry.mem_r_en = hif.id_mem_r_en;
    id_entry.mem_op   = hif.id_mem_r_en | hif.id_mem_w_en;
  end

  assign freeze = mem_q.valid & mem_q.mem_op & ~hif.mem_ready;

  assign m_exe = sb_match(exe_q, hif.src1, hif.src2, hif.two_src);
  assign m_mem = sb_match(mem_q, hif.src1, hif.src2, hif.two_src);
  assign m_wb  = sb_match(wb_q,  hif.src1, hif.src2, hif.two_src);

  // With forwarding only a load still in EXE cannot be bypassed in time.
  assign raw    = hif.forward_en ? (m_exe & exe_q.mem_r_en)
                                 : (m_exe | m_mem | (WB_CHECK & m_wb));
  assign hazard = raw & ~hif.flush & ~freeze;

  assign hif.hazard_detected = hazard;
  assign hif.freeze_all      = freeze;
  assign hif.mem_timeout_err = timeout_err;

  hazard_sb_entry u_exe (
    .clk    (clk),
    .rst    (rst),
    .hold   (freeze),
    .bubble (hif.flush | hazard),
    .d      (id_entry),
    .q      (exe_q)
  );

  hazard_sb_entry u_mem (
    .clk    (clk),
    .rst    (rst),
    .hold   (freeze),
    .bubble (1'b0),
    .d      (exe_q),
    .q      (mem_q)
  );

  hazard_sb_entry u_wb (
    .clk    (clk),
    .rst    (rst),
    .hold   (freeze),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  assign unused_fields = ^{mem_q.mem_r_en, wb_q.mem_r_en, wb_q.mem_op};

  // Counter value after this edge; counts completed freeze cycles, saturating.
  always_comb begin
    cnt_next = '0;
    if (freeze) begin
      if (state == RUN)         cnt_next = 8'd1;
      else if (wait_cnt == '1)  cnt_next = wait_cnt;
      else                      cnt_next = wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= cnt_next;
      if (freeze && (cnt_next >= MEM_TIMEOUT)) timeout_err <= 1'b1;
      case (state)
        RUN:     if (freeze)  state <= WAIT;
        WAIT:    if (!freeze) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, freeze_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (hazard) stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (freeze) freeze_cnt_q <= freeze_cnt_q + 32'd1;
    end
  end

  assign hif.stall_cnt  = stall_cnt_q;
  assign hif.freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench: dut0 uses defaults (WB_CHECK=0, MEM_TIMEOUT=16); dut1 sees the
// same stimulus with WB_CHECK=1 and MEM_TIMEOUT=1.
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       forward_en, two_src, id_wb_en, id_mem_r_en, id_mem_w_en, flush, mem_ready;
  logic [4:0] src1, src2, id_dest;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  hazard_detection_unit_if if0 ();
  hazard_detection_unit_if if1 ();

  assign if0.forward_en  = forward_en;   assign if1.forward_en  = forward_en;
  assign if0.src1        = src1;         assign if1.src1        = src1;
  assign if0.src2        = src2;         assign if1.src2        = src2;
  assign if0.two_src     = two_src;      assign if1.two_src     = two_src;
  assign if0.id_dest     = id_dest;      assign if1.id_dest     = id_dest;
  assign if0.id_wb_en    = id_wb_en;     assign if1.id_wb_en    = id_wb_en;
  assign if0.id_mem_r_en = id_mem_r_en;  assign if1.id_mem_r_en = id_mem_r_en;
  assign if0.id_mem_w_en = id_mem_w_en;  assign if1.id_mem_w_en = id_mem_w_en;
  assign if0.flush       = flush;        assign if1.flush       = flush;
  assign if0.mem_ready   = mem_ready;    assign if1.mem_ready   = mem_ready;

  hazard_detection_unit #(.MEM_TIMEOUT(8'd16), .WB_CHECK(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .hif (if0)
  );

  hazard_detection_unit #(.MEM_TIMEOUT(8'd1), .WB_CHECK(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .hif (if1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    src1 = '0; src2 = '0; two_src = 1'b0; id_dest = '0;
    id_wb_en = 1'b0; id_mem_r_en = 1'b0; id_mem_w_en = 1'b0; flush = 1'b0;
  endtask

  task automatic instr(input logic [4:0] s1, input logic [4:0] s2, input logic ts,
                       input logic [4:0] d, input logic wb, input logic mr, input logic mw);
    src1 = s1; src2 = s2; two_src = ts; id_dest = d;
    id_wb_en = wb; id_mem_r_en = mr; id_mem_w_en = mw;
  endtask

  task automatic drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      idle();
      mem_ready = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; forward_en = 1'b1; mem_ready = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hazard", if0.hazard_detected, 0);
    chk("rst_freeze", if0.freeze_all, 0);
    chk("rst_err0",   if0.mem_timeout_err, 0);
    chk("rst_err1",   if1.mem_timeout_err, 0);

    // Load R3 then add R5,R3,R1 with forwarding: exactly one stall.
    @(negedge clk); instr(5'd2, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); #1;
    chk("lu_load_issue", if0.hazard_detected, 0);
    @(negedge clk); instr(5'd3, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); #1;
    chk("lu_stall", if0.hazard_detected, 1);
    chk("lu_stall_dut1", if1.hazard_detected, 1);
    @(negedge clk); #1;
    chk("lu_release", if0.hazard_detected, 0);
    chk("lu_release_dut1", if1.hazard_detected, 0);
    drain(3);

    // No forwarding: add R4 then sub reading R4 as src2.
    forward_en = 1'b0;
    @(negedge clk); instr(5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); #1;
    chk("nf_add_issue", if0.hazard_detected, 0);
    @(negedge clk); instr(5'd6, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); #1;
    chk("nf_stall1", if0.hazard_detected, 1);
    chk("nf_stall1_wb", if1.hazard_detected, 1);
    @(negedge clk); #1;
    chk("nf_stall2", if0.hazard_detected, 1);
    chk("nf_stall2_wb", if1.hazard_detected, 1);
    @(negedge clk); #1;
    chk("nf_release", if0.hazard_detected, 0);
    chk("nf_stall3_wb", if1.hazard_detected, 1);
    @(negedge clk); #1;
    chk("nf_release_wb", if1.hazard_detected, 0);
    drain(3);

    // R0 never hazards; src2 ignored unless two_src.
    @(negedge clk); instr(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); #1;
    chk("r0_writer", if0.hazard_detected, 0);
    @(negedge clk); instr(5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); #1;
    chk("r0_reader", if0.hazard_detected, 0);
    chk("r0_reader_dut1", if1.hazard_detected, 0);
    @(negedge clk); instr(5'd1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); #1;
    chk("r9_writer", if0.hazard_detected, 0);
    @(negedge clk); instr(5'd8, 5'd9, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0); #1;
    chk("two_src_off", if0.hazard_detected, 0);
    @(negedge clk); instr(5'd8, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0); #1;
    chk("two_src_on", if0.hazard_detected, 1);
    drain(3);

    // Store in MEM with mem_ready low 4 cycles; writer R10 sits in EXE meanwhile.
    @(negedge clk); instr(5'd2, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); #1;
    chk("mw_store_issue", if0.hazard_detected, 0);
    @(negedge clk); instr(5'd1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0); #1;
    chk("mw_writer_issue", if0.hazard_detected, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); instr(5'd10, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0); mem_ready = 1'b0; #1;
      chk("mw_freeze", if0.freeze_all, 1);
      chk("mw_no_stall", if0.hazard_detected, 0);
      if (i == 0) chk("mw_tmo1_not_yet", if1.mem_timeout_err, 0);
      if (i == 1) chk("mw_tmo1_set", if1.mem_timeout_err, 1);
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("mw_unfreeze", if0.freeze_all, 0);
    chk("mw_exe_held", if0.hazard_detected, 1);
    chk("mw_no_err", if0.mem_timeout_err, 0);
    @(negedge clk); #1;
    chk("mw_mem_stage", if0.hazard_detected, 1);
    chk("mw_no_freeze_after", if0.freeze_all, 0);
    drain(3);
    forward_en = 1'b1;

    // Timeout: 16 frozen cycles set the error, freezing continues, error is sticky.
    @(negedge clk); instr(5'd2, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); idle();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); mem_ready = 1'b0; #1;
      chk("tmo_freeze", if0.freeze_all, 1);
      if (i == 16) chk("tmo_err_pre", if0.mem_timeout_err, 0);
    end
    @(negedge clk); #1;
    chk("tmo_err_set", if0.mem_timeout_err, 1);
    chk("tmo_still_frozen", if0.freeze_all, 1);
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("tmo_unfreeze", if0.freeze_all, 0);
    chk("tmo_err_sticky", if0.mem_timeout_err, 1);
    drain(2); #1;
    chk("tmo_err_sticky2", if0.mem_timeout_err, 1);

    // Reset while in WAIT.
    @(negedge clk); instr(5'd2, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); idle();
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("rw_freeze", if0.freeze_all, 1);
    @(negedge clk); #1; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rw_freeze_cleared", if0.freeze_all, 0);
    chk("rw_err_cleared", if0.mem_timeout_err, 0);
    @(negedge clk); #1;
    chk("rw_err_stays_clear", if0.mem_timeout_err, 0);
    drain(3);

    // Flush colliding with a load-use pair.
    @(negedge clk); instr(5'd2, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); #1;
    chk("fl_load_issue", if0.hazard_detected, 0);
    @(negedge clk); instr(5'd3, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); flush = 1'b1; #1;
    chk("fl_flush_wins", if0.hazard_detected, 0);
    @(negedge clk); flush = 1'b0; forward_en = 1'b0;
    instr(5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0); #1;
    chk("fl_bubble", if0.hazard_detected, 0);
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk); #1;
    chk("perf_stall_after_flush", if0.stall_cnt, 0);
    chk("perf_freeze_after_rst", if0.freeze_cnt, 0);
    forward_en = 1'b1;
    @(negedge clk); instr(5'd2, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk); instr(5'd3, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); #1;
    chk("perf_stall_seen", if0.hazard_detected, 1);
    @(negedge clk); #1;
    chk("perf_stall_cnt", if0.stall_cnt, 1);
`endif
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Decides when the ID-stage instruction must stall, so it complements the forwarding unit that resolves the hazards that can be forwarded.
- Keeps an internal destination scoreboard for the EXE, MEM and WB stages, advanced in lockstep with the pipeline registers.
- Outputs: load-use / no-forward stall (`hazard_detected`), whole-pipe freeze during multi-cycle memory access (`freeze_all`), and a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 16, max consecutive `freeze_all` cycles before `mem_timeout_err` sets; width 8 bits, legal range 1..255.
- WB_CHECK, 0, 1 = also compare against the WB-stage entry when forwarding is off (use for a register file without write-first behaviour).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- forward_en  in  1  forwarding enabled (forwarding unit active)
- src1  in  5  ID source register 1
- src2  in  5  ID source register 2
- two_src  in  1  src2 is actually read (R-type or store)
- id_dest  in  5  ID destination
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- id_mem_w_en  in  1  ID instruction is a store
- flush  in  1  taken branch resolved in EXE; kills the ID instruction
- mem_ready  in  1  data memory completes the access this cycle
- hazard_detected  out  1  freeze PC and IF/ID; bubble into ID/EXE
- freeze_all  out  1  hold every pipeline register
- mem_timeout_err  out  1  sticky, set on memory timeout

Behaviour:
- Scoreboard: three entries (EXE, MEM, WB), each holding {valid, dest[4:0], wb_en, mem_r_en, mem_op}. `mem_op` = mem_r_en | mem_w_en.
- Reset: all entries invalid; all outputs 0; wait counter 0; `mem_timeout_err` 0.
- `freeze_all` = MEM.valid & MEM.mem_op & ~mem_ready. Combinational, zero latency.
- Match(e), for e in {EXE, MEM, WB}: e.valid & e.wb_en & (e.dest != 0) & ((e.dest == src1) | (two_src & e.dest == src2)).
- Raw hazard:
  - forward_en=1: Match(EXE) & EXE.mem_r_en (load-use only).
  - forward_en=0: Match(EXE) | Match(MEM) | (WB_CHECK & Match(WB)).
- `hazard_detected` = raw & ~flush & ~freeze_all. Combinational.
- Register 0 never causes a hazard.
- Clock edge, in priority order:
  - rst: clear everything.
  - freeze_all: all entries hold.
  - otherwise: WB<=MEM, MEM<=EXE, and EXE loads as follows:
    - EXE <= bubble (valid=0) if flush or hazard_detected.
    - EXE <= ID fields with valid=1 otherwise.
- Net effect: a load followed by a dependent instruction gives exactly 1 stall cycle with forwarding, and up to 2 without (3 with WB_CHECK).
- Wait FSM, states RUN and WAIT:
  - RUN -> WAIT when freeze_all=1. The counter loads 1.
  - WAIT, freeze_all=1: counter increments, saturating at 255.
  - WAIT -> RUN when mem_ready=1 (freeze_all=0). Counter clears.
  - `mem_timeout_err` sets when the counter reaches MEM_TIMEOUT and stays set until rst.
  - Freezing continues after a timeout; the error output is for reporting only.
- Simultaneous events:
  - flush + hazard: flush wins; `hazard_detected`=0; bubble inserted.
  - freeze_all + flush: the freeze holds the scoreboard. Flush is reapplied when the freeze lifts, because the outer pipeline holds the flush condition.
  - rst mid-WAIT: return to RUN immediately.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN adds two outputs:
  - stall_cnt[31:0]: counts cycles with hazard_detected=1.
  - freeze_cnt[31:0]: counts cycles with freeze_all=1.
- Both reset to 0 and wrap on overflow.
- Without the macro these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package `hazard_pkg`:
  - scoreboard entry struct.
  - constant REG_ZERO=5'd0.
  - FSM state enum {RUN, WAIT}.
- Sub-module `hazard_sb_entry`: one scoreboard stage register with load/hold/bubble control, instantiated three times.
- Comparison and FSM logic live in the top module.

Test Plan:
- Load-use, forwarding on: issue load to R3, then add R5,R3,R1 with forward_en=1 -> hazard_detected=1 for exactly 1 cycle; EXE gets a bubble; add issues the next cycle.
- No forwarding: add writing R4, then sub reading R4 as src2 with two_src=1 and forward_en=0 -> hazard 2 cycles (WB_CHECK=0), 3 cycles (WB_CHECK=1).
- R0 and two_src: writer dest=0 followed by a reader of R0 -> no hazard; reader using src2=dest with two_src=0 -> no hazard.
- Memory wait: store reaches MEM, mem_ready held low 4 cycles -> freeze_all=1 for 4 cycles; scoreboard unchanged; FSM returns to RUN; no error.
- Timeout: mem_ready low 16 cycles with MEM_TIMEOUT=16 -> mem_timeout_err=1 on the 16th cycle, stays 1 after mem_ready; cleared only by rst.
- Flush/hazard collision: load-use pair plus flush=1 in the same cycle -> hazard_detected=0; EXE bubble; with HAZARD_PERF_CNT_EN, stall_cnt does not increment.
